// File: rtl/beneater_pkg.sv
// beneater_pkg: shared constants and types for the loader and RAM
package beneater_pkg;
  localparam int RAM_DEPTH = 16;
  localparam int RAM_AW = 4;
  typedef enum logic [2:0] {LD_IDLE, LD_RECV, LD_CHECK, LD_STREAM, LD_FIN} ld_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/prog_loader_uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchronizer, mid-bit sampling and framing check
module uart_rx
  import beneater_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rx,
  output logic  start_edge,
  output logic  busy,
  output logic  rx_valid,
  output byte_t rx_byte,
  output logic  frame_err
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  logic s1_q, s2_q, prev_q;
  rx_state_t st_q, st_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0] bit_q, bit_d;
  byte_t sh_q, sh_d, byte_q, byte_d;
  logic vld_q, vld_d, fe_q, fe_d;
  assign start_edge = (st_q == RX_IDLE) && prev_q && !s2_q;
  assign busy = st_q != RX_IDLE;
  assign rx_valid = vld_q;
  assign rx_byte = byte_q;
  assign frame_err = fe_q;
  // bit timer and sampling state machine; falling edge (not level) arms a start
  always_comb begin
    st_d = st_q;
    tmr_d = tmr_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    byte_d = byte_q;
    vld_d = 1'b0;
    fe_d = 1'b0;
    case (st_q)
      RX_IDLE: begin
        tmr_d = '0;
        if (start_edge) st_d = RX_START;
      end
      RX_START: if (tmr_q == HALF) begin
        tmr_d = '0;
        bit_d = '0;
        st_d = s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (tmr_q == FULL) begin
        tmr_d = '0;
        sh_d = {s2_q, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) st_d = RX_STOP;
      end
      RX_STOP: if (tmr_q == FULL) begin
        st_d = RX_IDLE;
        vld_d = s2_q;
        fe_d = !s2_q;
        byte_d = sh_q;
      end
      default: st_d = RX_IDLE;
    endcase
  end
  // synchronizer plus receiver state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      prev_q <= 1'b1;
      st_q <= RX_IDLE;
      tmr_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      byte_q <= '0;
      vld_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      s1_q <= rx;
      s2_q <= s1_q;
      prev_q <= s2_q;
      st_q <= st_d;
      tmr_q <= tmr_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      byte_q <= byte_d;
      vld_q <= vld_d;
      fe_q <= fe_d;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: UART image buffer that bursts 16 bytes into the RAM; PROG_LOADER_CHECKSUM_EN adds a 17th checksum byte
module prog_loader
  import beneater_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       prog_mode,
  output logic [7:0] w_data,
  output logic       cpu_halt,
  output logic       done,
  output logic       err
);
  logic start_edge, busy, rx_valid, frame_err;
  byte_t rx_byte;
  ld_state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d, scnt_q, scnt_d;
  logic pm_q, pm_d, halt_q, halt_d, done_q, done_d, err_q, err_d, wr_en;
  byte_t wd_q, wd_d;
  byte_t mem_q [RAM_DEPTH];
`ifdef PROG_LOADER_CHECKSUM_EN
  byte_t sum_q, sum_d;
`endif
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst(rst), .rx(rx), .start_edge(start_edge), .busy(busy),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .frame_err(frame_err)
  );
  assign prog_mode = pm_q;
  assign w_data = wd_q;
  assign cpu_halt = halt_q;
  assign done = done_q;
  assign err = err_q;
  // loader FSM; outputs are computed one state ahead so they come straight from flops
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    scnt_d = scnt_q;
    pm_d = 1'b0;
    wd_d = 8'h00;
    halt_d = halt_q;
    done_d = 1'b0;
    err_d = err_q;
    wr_en = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d = sum_q;
`endif
    case (state_q)
      LD_IDLE: begin
        cnt_d = '0;
        halt_d = start_edge | (halt_q & busy);
        if (rx_valid) begin
          wr_en = 1'b1;
          cnt_d = 5'd1;
          err_d = 1'b0;
          halt_d = 1'b1;
          state_d = LD_RECV;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d = rx_byte;
`endif
        end
      end
      LD_RECV: if (rx_valid) begin
        cnt_d = cnt_q + 5'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
        if (cnt_q == 5'(RAM_DEPTH)) begin
          sum_d = sum_q - rx_byte;
          state_d = LD_CHECK;
        end else begin
          wr_en = 1'b1;
          sum_d = sum_q + rx_byte;
        end
`else
        wr_en = 1'b1;
        if (cnt_q == 5'(RAM_DEPTH - 1)) begin
          state_d = LD_STREAM;
          scnt_d = '0;
          pm_d = 1'b1;
        end
`endif
      end
      LD_CHECK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (sum_q == 8'h00) begin
          state_d = LD_STREAM;
          scnt_d = '0;
          pm_d = 1'b1;
        end else begin
          err_d = 1'b1;
          halt_d = 1'b0;
          cnt_d = '0;
          state_d = LD_IDLE;
        end
`else
        state_d = LD_IDLE;
`endif
      end
      LD_STREAM: if (scnt_q == 5'(RAM_DEPTH)) begin
        state_d = LD_FIN;
        done_d = 1'b1;
        halt_d = 1'b0;
        scnt_d = '0;
        cnt_d = '0;
      end else begin
        pm_d = 1'b1;
        wd_d = mem_q[scnt_q[RAM_AW-1:0]];
        scnt_d = scnt_q + 5'd1;
      end
      LD_FIN: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
    if (frame_err || (rx_valid && (state_q inside {LD_CHECK, LD_STREAM, LD_FIN}))) begin
      state_d = LD_IDLE;
      err_d = 1'b1;
      cnt_d = '0;
      scnt_d = '0;
      halt_d = 1'b0;
      pm_d = 1'b0;
      wd_d = 8'h00;
      done_d = 1'b0;
      wr_en = 1'b0;
    end
  end
  // image buffer; contents are irrelevant until fully received
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[cnt_q[RAM_AW-1:0]] <= rx_byte;
  end
  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LD_IDLE;
      cnt_q <= '0;
      scnt_q <= '0;
      pm_q <= 1'b0;
      wd_q <= 8'h00;
      halt_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      scnt_q <= scnt_d;
      pm_q <= pm_d;
      wd_q <= wd_d;
      halt_q <= halt_d;
      done_q <= done_d;
      err_q <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q <= sum_d;
`endif
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed UART images against prog_loader with burst, error and reset checks
module tb_prog_loader;
  import beneater_pkg::*;
  localparam int CPB = 8;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic prog_mode, cpu_halt, done, err;
  logic [7:0] w_data;
  int errors = 0, checks = 0;
  int pm_n = 0, pm_runs = 0, done_n = 0, halt_rise = 0, halt_fall = 0, halt_bad = 0, done_prev_pm = 0, rxv_n = 0;
  logic pm_prev = 1'b0, halt_prev = 1'b0;
  logic [7:0] wd_log [32];
  byte_t img [16];

  always #5 clk = ~clk;

  prog_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .prog_mode(prog_mode), .w_data(w_data),
    .cpu_halt(cpu_halt), .done(done), .err(err)
  );

  always @(negedge clk) begin
    if (prog_mode) begin
      if (pm_n < 32) wd_log[pm_n] = w_data;
      pm_n++;
      if (!pm_prev) pm_runs++;
      if (!cpu_halt) halt_bad++;
    end
    if (done) begin
      done_n++;
      done_prev_pm = int'(pm_prev);
    end
    if (cpu_halt && !halt_prev) halt_rise++;
    if (!cpu_halt && halt_prev && !done) halt_fall++;
    if (dut.rx_valid) rxv_n++;
    pm_prev = prog_mode;
    halt_prev = cpu_halt;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    #1;
    pm_n = 0; pm_runs = 0; done_n = 0; halt_rise = 0; halt_fall = 0;
    halt_bad = 0; done_prev_pm = 0; rxv_n = 0;
  endtask

  task automatic send_byte(input byte_t b, input logic stop);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_image(input int from, input logic bad_ck);
    byte_t s;
    s = bad_ck ? 8'h01 : 8'h00;
    for (int i = 0; i < 16; i++) s = s + img[i];
    for (int i = from; i < 16; i++) send_byte(img[i], 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(s, 1'b1);
`endif
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 400 && done_n == 0; i++) @(negedge clk);
    check({tag, "_done_seen"}, done_n != 0, 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_burst(input string tag);
    check({tag, "_pm_cycles"}, pm_n, 17);
    check({tag, "_pm_runs"}, pm_runs, 1);
    check({tag, "_wd0"}, wd_log[0], 8'h00);
    for (int k = 1; k <= 16; k++) check($sformatf("%s_wd%0d", tag, k), wd_log[k], img[k-1]);
    check({tag, "_done_n"}, done_n, 1);
    check({tag, "_done_after_pm"}, done_prev_pm, 1);
    check({tag, "_halt_rise"}, halt_rise, 1);
    check({tag, "_halt_early_fall"}, halt_fall, 0);
    check({tag, "_halt_in_burst"}, halt_bad, 0);
    check({tag, "_halt_end"}, cpu_halt, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_state"}, dut.state_q, LD_IDLE);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int i;
    repeat (3) @(negedge clk);
    check("rst_prog_mode", prog_mode, 0);
    check("rst_w_data", w_data, 8'h00);
    check("rst_cpu_halt", cpu_halt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_state", dut.state_q, LD_IDLE);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 16; k++) img[k] = 8'(k);
    clr();
    send_image(0, 1'b0);
    wait_done("ramp");
    check_burst("ramp");

    clr();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_rx_valid", rxv_n, 0);
    check("glitch_err", err, 0);
    check("glitch_halt", cpu_halt, 0);
    check("glitch_pm", pm_n, 0);
    check("glitch_state", dut.state_q, LD_IDLE);

    for (int k = 0; k < 16; k++) img[k] = 8'h30 + 8'(k);
    clr();
    for (int k = 0; k < 3; k++) send_byte(img[k], 1'b1);
    send_byte(img[3], 1'b0);
    repeat (20) @(negedge clk);
    check("frame_err", err, 1);
    check("frame_halt", cpu_halt, 0);
    check("frame_pm", pm_n, 0);
    check("frame_state", dut.state_q, LD_IDLE);
    for (int k = 0; k < 16; k++) img[k] = 8'hA0 + 8'(k);
    clr();
    send_byte(img[0], 1'b1);
    repeat (2) @(negedge clk);
    check("clean_err_cleared", err, 0);
    check("clean_halt", cpu_halt, 1);
    send_image(1, 1'b0);
    wait_done("clean");
    check_burst("clean");

`ifdef PROG_LOADER_CHECKSUM_EN
    for (int k = 0; k < 16; k++) img[k] = 8'h11;
    clr();
    send_image(0, 1'b0);
    wait_done("ck_good");
    check_burst("ck_good");
    clr();
    send_image(0, 1'b1);
    repeat (40) @(negedge clk);
    check("ck_bad_pm", pm_n, 0);
    check("ck_bad_done", done_n, 0);
    check("ck_bad_err", err, 1);
    check("ck_bad_halt", cpu_halt, 0);
`endif

    for (int k = 0; k < 16; k++) img[k] = 8'(k);
    clr();
    send_image(0, 1'b0);
    for (i = 0; i < 200 && pm_n < 6; i++) begin
      @(negedge clk);
      #1;
    end
    check("mid_rst_at_scnt5", pm_n, 6);
    check("mid_rst_wd_scnt5", w_data, 8'h04);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_pm", prog_mode, 0);
    check("mid_rst_wd", w_data, 8'h00);
    check("mid_rst_halt", cpu_halt, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_state", dut.state_q, LD_IDLE);
    check("mid_rst_scnt", dut.scnt_q, 0);
    check("mid_rst_cnt", dut.cnt_q, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_rst_no_done", done_n, 0);
    check("mid_rst_no_more_pm", pm_n, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader that sits directly upstream of the 16-byte RAM. It receives a program image over a UART line (8N1) and buffers 16 bytes. It then drives the RAM's `prog_mode` / `w_data` inputs in one contiguous burst: one counter-clear cycle followed by 16 write cycles. While a load is in progress it holds the CPU halted.

## Interface
- `CLKS_PER_BIT`, default 1042: system clocks per UART bit (10 MHz / 9600 baud). Must be ≥ 4.
- `RAM_DEPTH`, default 16: bytes per image. Taken from the package constant.
- `clk`, input, 1: system clock. This is the only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `rx`, input, 1: asynchronous UART line; idles high.
- `prog_mode`, output, 1: connects to RAM `prog_mode`.
- `w_data`, output, 8: connects to RAM `w_data`.
- `cpu_halt`, output, 1: high from the first start bit of an image until `done`.
- `done`, output, 1: one-cycle pulse after a burst completes.
- `err`, output, 1: sticky error flag.

## Operation
- `rx` passes through a 2-flop synchronizer. All UART timing is measured on the synchronized signal.
- UART receive:
  - A falling edge starts a bit timer.
  - At `CLKS_PER_BIT/2` the line is re-sampled. If it is high, the start is false and the receiver returns to idle with no error.
  - Data bits are sampled LSB first, each at mid-bit.
  - If the stop bit samples low, that is a framing error.
  - On a good stop sample, `rx_valid` pulses for one cycle with `rx_byte`.
- Loader FSM states:
  - IDLE: `cnt=0`. A start bit sets `cpu_halt`. The first `rx_valid` clears `err`, stores `buf[0]`, and moves to RECV.
  - RECV: each `rx_valid` stores `buf[cnt]` and increments `cnt`.
    - After byte `RAM_DEPTH-1`, go to STREAM (or to CHECK when checksum is enabled).
  - CHECK: compare and branch (see Configuration).
  - STREAM: `prog_mode=1` for exactly `RAM_DEPTH+1` consecutive cycles. A 5-bit `scnt` runs 0..16.
    - `scnt=0`: `w_data=8'h00`. This is the RAM counter-clear (rising-edge) cycle.
    - `scnt=k` (1..16): `w_data=buf[k-1]`.
    - Then go to FIN.
  - FIN: `prog_mode=0`, `w_data=0`, `done=1`, `cpu_halt=0`. Go to IDLE.
- Errors set `err=1`, force `cnt=0`, drop `cpu_halt`, and return to IDLE without any `prog_mode` activity:
  - framing error in any state;
  - `rx_valid` arriving during CHECK, STREAM or FIN (overrun). The byte is discarded.
- `err` stays set until reset or until the first byte of the next image.
- The UART receiver keeps running in every FSM state.
- Partial images never reach the RAM.

## Timing
- Reset values: `prog_mode=0`, `w_data=8'h00`, `cpu_halt=0`, `done=0`, `err=0`, FSM in IDLE, `cnt=0`, `scnt=0`. Buffer contents are don't-care.
- Reset at any point, including mid-STREAM, drops `prog_mode` on the next edge and discards the image.
- `rx_valid` occurs `2 + 9.5*CLKS_PER_BIT` (±1) cycles after the start-bit falling edge on `rx`.
- Last `rx_valid` to first `prog_mode=1`:
  - 1 cycle without checksum;
  - 2 cycles with checksum (one CHECK cycle).
- `prog_mode` and `w_data` are registered outputs. `w_data` changes only on the same edges as `scnt`.
- `done` asserts the cycle after the last `prog_mode=1` cycle.
- `cpu_halt` asserts on the cycle after the synchronized start-bit edge in IDLE. It deasserts together with the `done` pulse.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - Each image carries a 17th byte: the 8-bit sum, mod 256, of the 16 payload bytes.
  - RECV runs until the checksum byte arrives, then goes to CHECK.
  - Match: go to STREAM.
  - Mismatch: set `err`, drop `cpu_halt`, return to IDLE, no burst.
- `PROG_LOADER_CHECKSUM_EN` undefined:
  - Images are exactly 16 bytes.
  - No CHECK state and no accumulator.
  - The 16th byte goes directly to STREAM.

## Structure
- Shared package `beneater_pkg`:
  - `RAM_DEPTH=16`, `RAM_AW=4`;
  - `typedef enum logic [2:0] {LD_IDLE, LD_RECV, LD_CHECK, LD_STREAM, LD_FIN} ld_state_t`;
  - `typedef logic [7:0] byte_t`.
- One sub-module, `uart_rx`, contains the synchronizer, bit timer and shift register. It outputs `rx_valid`, `rx_byte` and `frame_err`.
- `prog_loader` holds the FSM, the buffer and the checksum logic.

## Test plan
Run all scenarios with `CLKS_PER_BIT=8`.
- 16 bytes 0x00..0x0F, checksum disabled:
  - `prog_mode` high 17 cycles;
  - `w_data` = 0x00, 0x00, 0x01 … 0x0F;
  - `done` pulses once;
  - `cpu_halt` high from the first start bit to `done`.
- Checksum enabled, 16×0x11 followed by 0x10: burst streams sixteen 0x11, `err=0`.
- Checksum enabled, 16×0x11 followed by 0x11: no `prog_mode` pulse, `err=1`, `cpu_halt=0`.
- Stop bit forced low on byte 3: `err=1`, no burst. Then a clean image: `err` clears on its first byte and the burst streams correctly.
- `rst` asserted at `scnt=5`: `prog_mode=0` the next cycle, all outputs at reset values, no `done`.
- A 0.25-bit low glitch on `rx`: no byte received, `err=0`, FSM remains in IDLE. `cpu_halt` may pulse and must return to 0.
